// File: rtl/shfloat_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shfloat_framer_pkg
// Description : Shared types and constants for the shfloat byte framer.
// Revision    : 1.0 - initial release
// ============================================================================
package shfloat_framer_pkg;

  // Framer states; IDX and PAY walk a byte counter.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC0 = 3'd1,
    ST_SYNC1 = 3'd2,
    ST_SEQ   = 3'd3,
    ST_IDX   = 3'd4,
    ST_PAY   = 3'd5
  } state_t;

  localparam logic [7:0] SYNC0_BYTE   = 8'hA5;
  localparam logic [7:0] SYNC1_BYTE   = 8'h5A;
  localparam int         HEADER_BYTES = 7;

endpackage
`default_nettype wire

// File: rtl/shfloat_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : shfloat_word_fifo
// Description : Single-clock FIFO with a lookahead read port. o_peek shows the
//               head entry, or the entry behind it while a pop is being taken,
//               so a registered consumer can load the post-pop head in the
//               same cycle. The lookahead is only meaningful with count >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module shfloat_word_fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_peek,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int c_depth = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [c_depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_pop_ok;
  logic                  w_push_ok;
  logic [DEPTH_LOG2-1:0] w_rd_addr;

  assign o_full    = (r_count == (DEPTH_LOG2+1)'(c_depth));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_pop_ok  = i_pop && !o_empty;
  // A push into a full FIFO is fine when a pop frees a slot in the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign w_rd_addr = w_pop_ok ? (r_rd_ptr + DEPTH_LOG2'(1)) : r_rd_ptr;
  assign o_peek    = r_mem[w_rd_addr];

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/shfloat_framer.sv
`default_nettype none
// ============================================================================
// Module      : shfloat_framer
// Description : Buffers {index, packed} words and emits fixed-size frames
//               (A5 5A seq idx[4] payload[4*FRAME_WORDS]) on a valid/ready
//               byte interface. Counts words dropped on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module shfloat_framer
  import shfloat_framer_pkg::*;
#(
  parameter int PACKED_DEPTH    = 32,
  parameter int INDEX_DEPTH     = 32,
  parameter int FIFO_DEPTH_LOG2 = 6,
  parameter int FRAME_WORDS     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_DEPTH-1:0]  in_index,
  input  logic [PACKED_DEPTH-1:0] in_pack,
  input  logic                    in_strobe,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_frame_start,
  output logic [15:0]             overflow_count
);

  localparam int c_pay_bytes = 4 * FRAME_WORDS;
  localparam int c_cnt_w     = (c_pay_bytes > 4) ? $clog2(c_pay_bytes) : 2;
  localparam int c_width     = INDEX_DEPTH + PACKED_DEPTH;
  localparam logic [c_cnt_w-1:0]       c_cnt_pay_last = c_cnt_w'(c_pay_bytes - 1);
  localparam logic [c_cnt_w-1:0]       c_cnt_idx_last = c_cnt_w'(3);
  localparam logic [FIFO_DEPTH_LOG2:0] c_frame_cnt    = (FIFO_DEPTH_LOG2+1)'(FRAME_WORDS);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [c_cnt_w-1:0]       r_cnt;
  logic [c_cnt_w-1:0]       w_cnt_nxt;
  logic [7:0]               r_seq;
  logic                     w_seq_inc;
  logic                     w_hs;
  logic                     w_pop;
  logic [c_width-1:0]       w_peek;
  logic [INDEX_DEPTH-1:0]   w_peek_idx;
  logic [PACKED_DEPTH-1:0]  w_peek_pack;
  logic                     w_full;
  logic                     w_empty;
  logic [FIFO_DEPTH_LOG2:0] w_count;
  logic [4:0]               w_sel;
  logic [7:0]               w_byte_nxt;

  assign w_hs        = out_valid && out_ready;
  assign w_peek_idx  = w_peek[PACKED_DEPTH +: INDEX_DEPTH];
  assign w_peek_pack = w_peek[PACKED_DEPTH-1:0];
  assign w_sel       = {w_cnt_nxt[1:0], 3'b000};

  shfloat_word_fifo #(
    .WIDTH      (c_width),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_strobe),
    .i_data  ({in_index, in_pack}),
    .i_pop   (w_pop),
    .o_peek  (w_peek),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Next-state, byte counter and pop decisions; everything but IDLE exit waits on a handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_seq_inc   = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_count >= c_frame_cnt) w_state_nxt = ST_SYNC0;
      ST_SYNC0: if (w_hs) w_state_nxt = ST_SYNC1;
      ST_SYNC1: if (w_hs) w_state_nxt = ST_SEQ;
      ST_SEQ: begin
        if (w_hs) begin
          w_state_nxt = ST_IDX;
          w_cnt_nxt   = '0;
        end
      end
      ST_IDX: begin
        if (w_hs) begin
          if (r_cnt == c_cnt_idx_last) begin
            w_state_nxt = ST_PAY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
      ST_PAY: begin
        if (w_hs) begin
          w_pop = (r_cnt[1:0] == 2'd3) && !w_empty;
          if (r_cnt == c_cnt_pay_last) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_seq_inc   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Byte to present next cycle; payload uses the FIFO lookahead across a pop.
  always_comb begin
    w_byte_nxt = 8'h00;
    case (w_state_nxt)
      ST_SYNC0: w_byte_nxt = SYNC0_BYTE;
      ST_SYNC1: w_byte_nxt = SYNC1_BYTE;
      ST_SEQ:   w_byte_nxt = r_seq;
      ST_IDX:   w_byte_nxt = w_peek_idx[w_sel +: 8];
      ST_PAY:   w_byte_nxt = w_peek_pack[w_sel +: 8];
      default:  w_byte_nxt = 8'h00;
    endcase
  end

  // Framer state, sequence number and registered byte-stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_seq           <= 8'h00;
      out_data        <= 8'h00;
      out_valid       <= 1'b0;
      out_frame_start <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      if (w_seq_inc) r_seq <= r_seq + 8'd1;
      out_data        <= w_byte_nxt;
      out_valid       <= (w_state_nxt != ST_IDLE);
      out_frame_start <= (w_state_nxt == ST_SYNC0);
    end
  end

  // Saturating count of words refused because the FIFO was full with no pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_count <= 16'h0000;
    end else if (in_strobe && w_full && !w_pop && (overflow_count != 16'hFFFF)) begin
      overflow_count <= overflow_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shfloat_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shfloat_framer
// Description : Self-checking bench for shfloat_framer: table of frame
//               scenarios plus overflow, mid-frame reset and seq wrap runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shfloat_framer;
  import shfloat_framer_pkg::*;

  localparam int FRAME_LEN = HEADER_BYTES + 4 * 16;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic [31:0] in_index  = '0;
  logic [31:0] in_pack   = '0;
  logic        in_strobe = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_frame_start;
  logic [15:0] overflow_count;

  int          checks = 0;
  int          failures = 0;
  int          ready_mode = 0;
  logic [8:0]  rx_q[$];
  int          stab_err = 0;
  int          gap_err = 0;
  int          valid_cycles = 0;
  int          mon_pos = 0;
  bit          gap_pend = 1'b0;
  bit          prev_hold = 1'b0;
  logic [7:0]  prev_data = '0;

  typedef struct {
    logic [31:0] idx0;
    logic [31:0] pk0;
    int          mode;
    logic [7:0]  seq;
  } vec_t;
  vec_t vecs[3];

  always #5 clk = ~clk;

  shfloat_framer dut (
    .clk             (clk),
    .rst             (rst),
    .in_index        (in_index),
    .in_pack         (in_pack),
    .in_strobe       (in_strobe),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_frame_start (out_frame_start),
    .overflow_count  (overflow_count)
  );

  // Sink ready: 0 = held low, 1 = held high, otherwise pseudo-random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Byte monitor: records accepted bytes, checks hold-while-stalled and inter-frame gap.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      mon_pos   = 0;
      gap_pend  = 1'b0;
    end else begin
      if (gap_pend) begin
        if (out_valid) gap_err++;
        gap_pend = 1'b0;
      end
      if (prev_hold && (!out_valid || out_data !== prev_data)) stab_err++;
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        rx_q.push_back({out_frame_start, out_data});
        mon_pos++;
        if (mon_pos == FRAME_LEN) begin
          mon_pos  = 0;
          gap_pend = 1'b1;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int b, input logic [31:0] idx0,
                                          input logic [31:0] pk0, input logic [7:0] seq);
    logic [31:0] w;
    if (b == 0) return 8'hA5;
    if (b == 1) return 8'h5A;
    if (b == 2) return seq;
    if (b < 7) begin
      w = idx0 >> (8 * (b - 3));
      return w[7:0];
    end
    w = pk0 + 32'((b - 7) / 4);
    w = w >> (8 * ((b - 7) % 4));
    return w[7:0];
  endfunction

  task automatic push_words(input logic [31:0] idx0, input logic [31:0] pk0, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_strobe = 1'b1;
      in_index  = idx0 + 32'(i);
      in_pack   = pk0 + 32'(i);
    end
    @(posedge clk);
    #1;
    in_strobe = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (rx_q.size() < n) begin
      checks++;
      failures++;
      $display("FAIL wait_bytes got=%0d required=%0d", rx_q.size(), n);
    end
  endtask

  task automatic check_frame(input logic [31:0] idx0, input logic [31:0] pk0, input logic [7:0] seq);
    logic [8:0] got;
    logic [8:0] exp;
    if (rx_q.size() < FRAME_LEN) return;
    for (int b = 0; b < FRAME_LEN; b++) begin
      got = rx_q.pop_front();
      exp = {(b == 0), exp_byte(b, idx0, pk0, seq)};
      chk($sformatf("frame seq=%0d byte=%0d {start,data}", seq, b), 32'(got), 32'(exp));
    end
  endtask

  initial begin
    int vc0;
    vecs[0] = '{32'd100,      32'h12345678, 1, 8'h00};
    vecs[1] = '{32'd200,      32'hA0B0C0FE, 2, 8'h01};
    vecs[2] = '{32'hDEADBEEF, 32'hFFFFFFF8, 2, 8'h02};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_frame_start", 32'(out_frame_start), 32'd0);
    chk("reset overflow_count", 32'(overflow_count), 32'd0);
    rst = 1'b0;

    // Table-driven frames: latency to first A5, then full byte stream
    for (int v = 0; v < 3; v++) begin
      ready_mode = vecs[v].mode;
      push_words(vecs[v].idx0, vecs[v].pk0, 16);
      @(negedge clk);
      #1;
      chk("latency idle after 16th push", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("latency out_valid", 32'(out_valid), 32'd1);
      chk("latency out_data A5", 32'(out_data), 32'hA5);
      chk("latency frame_start", 32'(out_frame_start), 32'd1);
      wait_bytes(FRAME_LEN, 2000);
      check_frame(vecs[v].idx0, vecs[v].pk0, vecs[v].seq);
      repeat (3) @(negedge clk);
      #1;
      chk("stall stability errors", 32'(stab_err), 32'd0);
      chk("inter-frame gap errors", 32'(gap_err), 32'd0);
    end

    // Overflow: sink stalled, 70 words into a 64-entry FIFO
    ready_mode = 0;
    repeat (2) @(posedge clk);
    push_words(32'd0, 32'hC0000000, 70);
    repeat (5) @(negedge clk);
    #1;
    chk("overflow_count after 70 pushes", 32'(overflow_count), 32'd6);
    chk("no bytes accepted while stalled", 32'(rx_q.size()), 32'd0);
    chk("stalled out_valid", 32'(out_valid), 32'd1);
    chk("stalled out_data", 32'(out_data), 32'hA5);
    ready_mode = 1;
    for (int k = 0; k < 4; k++) begin
      wait_bytes(FRAME_LEN, 1000);
      check_frame(32'(16 * k), 32'hC0000000 + 32'(16 * k), 8'(3 + k));
    end
    repeat (5) @(negedge clk);
    #1;
    chk("overflow no extra frame", 32'(rx_q.size()), 32'd0);
    chk("overflow back-to-back gap errors", 32'(gap_err), 32'd0);
    chk("overflow_count held", 32'(overflow_count), 32'd6);

    // Reset mid-frame: asynchronous clear, then fresh frame
    push_words(32'd1000, 32'h55AA0000, 16);
    wait_bytes(10, 500);
    #1;
    rst = 1'b1;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset out_data", 32'(out_data), 32'd0);
    chk("async reset out_frame_start", 32'(out_frame_start), 32'd0);
    chk("async reset overflow_count", 32'(overflow_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_q.delete();
    vc0 = valid_cycles;
    repeat (30) @(negedge clk);
    #1;
    chk("no output after reset", 32'(valid_cycles - vc0), 32'd0);
    push_words(32'd2000, 32'h33330000, 16);
    wait_bytes(FRAME_LEN, 500);
    check_frame(32'd2000, 32'h33330000, 8'h00);

    // Sequence wrap over 257 frames starting from a clean reset
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_q.delete();
    for (int f = 0; f < 257; f++) begin
      push_words(32'(16 * f), 32'(f), 16);
      wait_bytes(FRAME_LEN, 500);
      check_frame(32'(16 * f), 32'(f), 8'(f));
    end
    repeat (3) @(negedge clk);
    #1;
    chk("final gap errors", 32'(gap_err), 32'd0);
    chk("final stability errors", 32'(stab_err), 32'd0);
    chk("final overflow_count", 32'(overflow_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
